// File: rtl/port_map_lookup.sv
// port_map_lookup: buffers the arbiter packet stream in a 4-word FIFO and
// rewrites the IOQ header destination field from a per-source-port map.
// Packets whose map entry is empty are consumed without being forwarded.
// Forwarded and dropped packets are counted on their EOP word.
module port_map_lookup #(
    parameter int                    DATA_WIDTH         = 64,
    parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = CTRL_WIDTH'(8'hff),
    parameter int                    NUM_PORTS          = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [CTRL_WIDTH-1:0]          in_ctrl,
    input  logic                           in_wr,
    output logic                           in_rdy,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    output logic                           out_wr,
    input  logic                           out_rdy,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] port_map,
    output logic [31:0]                    pkt_fwd_count,
    output logic [31:0]                    pkt_drop_count
);

    localparam int FW = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [0:0] {HDRS = 1'b0, PAYLOAD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           mem_q [4];
    logic [FW-1:0]           mem_d [4];
    logic [1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]              count_q, count_d;
    logic                    drop_q, drop_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
    logic                    out_wr_q, out_wr_d;
    logic [31:0]             pkt_fwd_count_q, pkt_fwd_count_d;
    logic [31:0]             pkt_drop_count_q, pkt_drop_count_d;

    logic                    fifo_empty_s, wr_en_s, consume_s, fwd_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic [CTRL_WIDTH-1:0]   head_ctrl_s;
    logic [NUM_PORTS-1:0]    mask_s;
    logic [15:0]             dst_s;
    logic                    is_ioq_hdr_s, is_eop_s, drop_now_s;

    assign fifo_empty_s   = (count_q == 3'd0);
    assign in_rdy         = (count_q < 3'd3);
    assign wr_en_s        = in_wr && (count_q != 3'd4);
    assign head_ctrl_s    = mem_q[rd_ptr_q][FW-1:DATA_WIDTH];
    assign head_data_s    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign out_data       = out_data_q;
    assign out_ctrl       = out_ctrl_q;
    assign out_wr         = out_wr_q;
    assign pkt_fwd_count  = pkt_fwd_count_q;
    assign pkt_drop_count = pkt_drop_count_q;

    // Map lookup: out-of-range source ports match no entry and yield an empty mask.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (head_data_s[31:16] == 16'(i)) begin
                mask_s = port_map[i*NUM_PORTS +: NUM_PORTS];
            end else begin
                mask_s = mask_s;
            end
        end
        dst_s = 16'h0000;
        dst_s[NUM_PORTS-1:0] = mask_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDRS;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: first ctrl==0 word enters PAYLOAD, EOP returns to HDRS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDRS: begin
                if (consume_s && (head_ctrl_s == '0)) begin
                    state_d = PAYLOAD;
                end else begin
                    state_d = HDRS;
                end
            end
            PAYLOAD: begin
                if (consume_s && (head_ctrl_s != '0)) begin
                    state_d = HDRS;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            default: state_d = HDRS;
        endcase
    end

    // FSM outputs: consume/forward decision, header rewrite, drop flag and counters.
    always_comb begin
        is_ioq_hdr_s     = (state_q == HDRS) && (head_ctrl_s == IO_QUEUE_STAGE_NUM);
        is_eop_s         = (state_q == PAYLOAD) && (head_ctrl_s != '0);
        drop_now_s       = is_ioq_hdr_s ? (mask_s == '0) : drop_q;
        consume_s        = !fifo_empty_s && (out_rdy || drop_now_s);
        fwd_s            = consume_s && !drop_now_s;
        out_wr_d         = fwd_s;
        out_ctrl_d       = out_ctrl_q;
        out_data_d       = out_data_q;
        drop_d           = drop_q;
        pkt_fwd_count_d  = pkt_fwd_count_q;
        pkt_drop_count_d = pkt_drop_count_q;
        if (fwd_s) begin
            out_ctrl_d = head_ctrl_s;
            if (is_ioq_hdr_s) begin
                out_data_d = {dst_s, head_data_s[DATA_WIDTH-17:0]};
            end else begin
                out_data_d = head_data_s;
            end
        end else begin
            out_ctrl_d = out_ctrl_q;
        end
        if (consume_s && is_ioq_hdr_s) begin
            drop_d = (mask_s == '0);
        end else if (consume_s && is_eop_s) begin
            drop_d = 1'b0;
            if (drop_q) begin
                pkt_drop_count_d = pkt_drop_count_q + 32'd1;
            end else begin
                pkt_fwd_count_d = pkt_fwd_count_q + 32'd1;
            end
        end else begin
            drop_d = drop_q;
        end
    end

    // FIFO pointer, occupancy and storage next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = {in_ctrl, in_data};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (consume_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, consume_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage: contents are don't-care when empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Datapath, control and counter registers; reset flushes the FIFO and drops any partial packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= 2'd0;
            rd_ptr_q         <= 2'd0;
            count_q          <= 3'd0;
            drop_q           <= 1'b0;
            out_data_q       <= '0;
            out_ctrl_q       <= '0;
            out_wr_q         <= 1'b0;
            pkt_fwd_count_q  <= 32'd0;
            pkt_drop_count_q <= 32'd0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            drop_q           <= drop_d;
            out_data_q       <= out_data_d;
            out_ctrl_q       <= out_ctrl_d;
            out_wr_q         <= out_wr_d;
            pkt_fwd_count_q  <= pkt_fwd_count_d;
            pkt_drop_count_q <= pkt_drop_count_d;
        end
    end

endmodule
